// File: rtl/align_divu.sv
// align_divu: sequential unsigned divider.
// The divisor is first aligned under the dividend by left shifts (ALIGN).
// One restoring shift-subtract step per clock then builds the quotient (DIVIDE).
// Start/done handshake with variable latency; sign handling is left to the wrapper.
module align_divu #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         divrst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] q,
  output logic [W-1:0] r,
  output logic         busy,
  output logic         done
);

  localparam int KW = $clog2(W);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ALIGN  = 2'd1,
    S_DIVIDE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_rem;
  logic [W-1:0]    r_shb;
  logic [W-1:0]    r_quo;
  logic [KW-1:0]   r_k;

  logic [W-1:0]    w_shb_dbl;
  logic            w_can_shift;
  logic            w_ge;
  logic [W-1:0]    w_rem_nxt;
  logic [W-1:0]    w_quo_nxt;

  // The MSB guard keeps the doubled divisor from wrapping past 2^W.
  assign w_shb_dbl   = {r_shb[W-2:0], 1'b0};
  assign w_can_shift = (r_shb[W-1] == 1'b0) && (w_shb_dbl <= r_rem);

  // Restoring step: subtract only when the aligned divisor fits.
  assign w_ge      = (r_rem >= r_shb);
  assign w_rem_nxt = w_ge ? (r_rem - r_shb) : r_rem;
  assign w_quo_nxt = {r_quo[W-2:0], w_ge};

  // Control FSM with datapath registers and registered result/handshake outputs.
  always_ff @(posedge clk or negedge divrst_n) begin
    if (!divrst_n) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_shb   <= '0;
      r_quo   <= '0;
      r_k     <= '0;
      q       <= '0;
      r       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rem <= a;
            r_shb <= b;
            r_quo <= '0;
            r_k   <= '0;
            if (b == '0) begin
              // Divide by zero: all-ones quotient, dividend as remainder.
              q       <= '1;
              r       <= a;
              done    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              busy    <= 1'b1;
              r_state <= S_ALIGN;
            end
          end
        end

        S_ALIGN: begin
          if (w_can_shift) begin
            r_shb <= w_shb_dbl;
            r_k   <= r_k + KW'(1);
          end else begin
            r_state <= S_DIVIDE;
          end
        end

        S_DIVIDE: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_shb <= r_shb >> 1;
          if (r_k == '0) begin
            q       <= w_quo_nxt;
            r       <= w_rem_nxt;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_k <= r_k - KW'(1);
          end
        end

        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_align_divu.sv
// Self-checking bench for align_divu (W=32): directed table, corner sequences,
// and randomized operands against a plain-arithmetic reference model.
// Edge numbering: start is driven just after edge 0 and sampled at edge 1.
module tb_align_divu;

  logic        clk;
  logic        divrst_n;
  logic        start;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] q;
  logic [31:0] r;
  logic        busy;
  logic        done;

  int pass_cnt = 0;
  int total    = 0;

  align_divu #(.W(32)) dut (
    .clk      (clk),
    .divrst_n (divrst_n),
    .start    (start),
    .a        (a_in),
    .b        (b_in),
    .q        (q),
    .r        (r),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Reference: quotient/remainder by native division; latency from the number
  // of doublings of b that still fit under a.
  function automatic void model(input logic [31:0] ma, input logic [31:0] mb,
                                output logic [31:0] mq, output logic [31:0] mr,
                                output int mlat);
    longint unsigned la, lb;
    int kk;
    la = {32'd0, ma};
    lb = {32'd0, mb};
    if (mb == 32'd0) begin
      mq = 32'hFFFF_FFFF;
      mr = ma;
      mlat = 1;
    end else begin
      mq = ma / mb;
      mr = ma % mb;
      kk = 0;
      while ((lb << (kk + 1)) <= la) kk++;
      mlat = 2 * kk + 3;
    end
  endfunction

  // Issue one operation; optionally pulse a spurious start at edge inj_at.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input int inj_at,
                        output logic [31:0] gq, output logic [31:0] gr,
                        output int lat, output bit hs_ok);
    @(posedge clk); #1;
    start = 1'b1;
    a_in  = ta;
    b_in  = tb_v;
    lat   = -1;
    hs_ok = 1'b1;
    gq    = 32'd0;
    gr    = 32'd0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (n == inj_at) begin
        start = 1'b1;
        a_in  = 32'd7;
        b_in  = 32'd2;
      end else begin
        start = 1'b0;
        a_in  = $urandom;
        b_in  = $urandom;
      end
      if (done) begin
        if (busy) hs_ok = 1'b0;
        gq  = q;
        gr  = r;
        lat = n;
        break;
      end else if (!busy) begin
        hs_ok = 1'b0;
      end
    end
    if (lat > 0) begin
      @(posedge clk); #1;
      if (done || busy || (q !== gq) || (r !== gr)) hs_ok = 1'b0;
    end else begin
      hs_ok = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] gq, gr, mq, mr, ra, rb;
    int lat, mlat, n_wait;
    bit hs_ok;

    vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,      9};
    vecs[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,      65};
    vecs[2] = '{32'd5,          32'd9,          32'd0,          32'd5,      3};
    vecs[3] = '{32'h8000_0000,  32'h8000_0000,  32'd1,          32'd0,      3};
    vecs[4] = '{32'h1234,       32'd0,          32'hFFFF_FFFF,  32'h1234,   1};
    vecs[5] = '{32'd1000,       32'd3,          32'd333,        32'd1,      19};

    divrst_n = 1'b0;
    start    = 1'b0;
    a_in     = 32'd0;
    b_in     = 32'd0;
    #12;
    check("reset_q",    {32'd0, q},    64'd0);
    check("reset_r",    {32'd0, r},    64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    divrst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, 0, gq, gr, lat, hs_ok);
      check($sformatf("vec%0d_q", i),   {32'd0, gq}, {32'd0, vecs[i].q});
      check($sformatf("vec%0d_r", i),   {32'd0, gr}, {32'd0, vecs[i].r});
      check($sformatf("vec%0d_lat", i), 64'(lat),    64'(vecs[i].lat));
      check($sformatf("vec%0d_hs", i),  {63'd0, hs_ok}, 64'd1);
    end

    // Start pulsed mid-operation must be ignored.
    run_op(32'd100, 32'd7, 4, gq, gr, lat, hs_ok);
    check("ign_q",   {32'd0, gq}, 64'd14);
    check("ign_r",   {32'd0, gr}, 64'd2);
    check("ign_lat", 64'(lat),    64'd9);

    // Reset in the middle of an operation.
    @(posedge clk); #1;
    start = 1'b1; a_in = 32'd1000; b_in = 32'd3;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("mid_busy_before", {63'd0, busy}, 64'd1);
    divrst_n = 1'b0;
    #1;
    check("mrst_q",    {32'd0, q},    64'd0);
    check("mrst_r",    {32'd0, r},    64'd0);
    check("mrst_busy", {63'd0, busy}, 64'd0);
    check("mrst_done", {63'd0, done}, 64'd0);
    #3;
    divrst_n = 1'b1;
    run_op(32'd1000, 32'd3, 0, gq, gr, lat, hs_ok);
    check("post_rst_q",   {32'd0, gq}, 64'd333);
    check("post_rst_r",   {32'd0, gr}, 64'd1);
    check("post_rst_lat", 64'(lat),    64'd19);

    // Start held high across DONE -> IDLE: a new request follows.
    @(posedge clk); #1;
    start = 1'b1; a_in = 32'd50; b_in = 32'd5;
    n_wait = 0;
    while (!done && n_wait < 200) begin
      @(posedge clk); #1; n_wait++;
    end
    check("held1_q", {32'd0, q}, 64'd10);
    check("held1_r", {32'd0, r}, 64'd0);
    a_in = 32'd63; b_in = 32'd8;
    @(posedge clk); #1;
    n_wait = 0;
    while (!done && n_wait < 200) begin
      @(posedge clk); #1; n_wait++;
    end
    start = 1'b0;
    check("held2_q", {32'd0, q}, 64'd7);
    check("held2_r", {32'd0, r}, 64'd7);
    // held2 starts one edge after DONE->IDLE; 63/8 has k=2, so 2k+3-1 edges after.
    check("held2_lat", 64'(n_wait), 64'd7);
    @(posedge clk); #1;

    // Randomized operands, back to back.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (i % 10 == 3) rb = 32'd0;
      if (i % 10 == 7) ra = $urandom_range(0, 50);
      model(ra, rb, mq, mr, mlat);
      run_op(ra, rb, (i % 3 == 0) ? 2 : 0, gq, gr, lat, hs_ok);
      check($sformatf("rnd%0d_q", i),   {32'd0, gq}, {32'd0, mq});
      check($sformatf("rnd%0d_r", i),   {32'd0, gr}, {32'd0, mr});
      check($sformatf("rnd%0d_lat", i), 64'(lat),    64'(mlat));
      check($sformatf("rnd%0d_hs", i),  {63'd0, hs_ok}, 64'd1);
      if (rb != 32'd0) begin
        check($sformatf("rnd%0d_inv", i),
              {32'd0, gq} * {32'd0, rb} + {32'd0, gr}, {32'd0, ra});
        check($sformatf("rnd%0d_rltb", i), {63'd0, (gr < rb)}, 64'd1);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
